spi_sample_scheduler: RTL and testbench
=======================================

Name: spi_sample_scheduler

Overview:
- Sequencer placed in front of the multi-MISO SPI receiver core.
- On a fixed sample period, it issues a frame of NumberOfSlots SPI transfers. Each transfer sends the command word from a small writable command table, for example an ADC channel-select word.
- For each slot it collects one 16-bit word from every MISO channel and publishes the complete frame atomically.
- It detects a missing completion (timeout) and period overrun, and reports both to the servo control logic.

Parameters:
- NumberOfMisoChannels, 1, number of parallel MISO channels delivered by the SPI core.
- NumberOfSlots, 4, transfers per frame (1..16).
- PeriodCycles, 2000, clock cycles per sample period (>=2).
- TimeoutCycles, 64, maximum cycles from EnableTransfer_o to SpiDataUpdated_i (>=2).

Ports:
- Clk_ik  in  1  system clock.
- Reset_i  in  1  synchronous, active-high reset.
- Run_i  in  1  level; enables periodic frames.
- ClearErrors_i  in  1  pulse; clears sticky error flags and the timeout counter.
- CmdWrite_i  in  1  command table write strobe.
- CmdAddr_ib4  in  4  command table slot index.
- CmdData_ib16  in  16  command word.
- EnableTransfer_o  out  1  one-cycle transfer request to the SPI core.
- Command_ob16  out  16  word for the SPI core Data input; held stable for the whole transfer.
- SpiData_ib  in  16*NumberOfMisoChannels  SPI core result; channel c occupies [c*16 +: 16].
- SpiDataUpdated_i  in  1  SPI core completion pulse.
- q_Result_ob  out  16*NumberOfMisoChannels*NumberOfSlots  published frame; slot s, channel c occupies [(s*NumberOfMisoChannels+c)*16 +: 16].
- q_FrameValid_o  out  1  one-cycle pulse; new frame published.
- q_Busy_o  out  1  high while a frame is in progress.
- q_TimeoutError_o  out  1  sticky flag.
- q_Overrun_o  out  1  sticky flag.
- q_TimeoutCount_ob8  out  8  saturating count of timeouts.

Behaviour:
- Reset: all outputs are 0. The command table, staging registers and q_Result_ob are 0. State is IDLE; all counters are 0.
- Period timer:
  - Counts 0..PeriodCycles-1 and wraps while Run_i=1.
  - Held at 0 while Run_i=0.
  - A tick occurs in the cycle the count equals PeriodCycles-1. The first tick therefore comes PeriodCycles cycles after Run_i rises.
- State IDLE:
  - When Run_i=1, go to WAIT_TICK.
- State WAIT_TICK:
  - On a tick: slot=0, go to ISSUE.
  - If Run_i=0: go to IDLE.
- State ISSUE (exactly one cycle):
  - EnableTransfer_o=1.
  - Command_ob16 is loaded from table[slot] on entry and held until the next ISSUE.
  - Timeout counter is cleared; next state is WAIT_DONE unconditionally.
- State WAIT_DONE:
  - On SpiDataUpdated_i: capture SpiData_ib into staging[slot].
    - If slot==NumberOfSlots-1, go to PUBLISH.
    - Otherwise slot++ and go to ISSUE.
  - If the timeout counter reaches TimeoutCycles-1 without SpiDataUpdated_i:
    - Set q_TimeoutError_o and increment q_TimeoutCount_ob8 (saturates at 255).
    - Discard the frame and go to WAIT_TICK.
  - If SpiDataUpdated_i arrives in the same cycle as the timeout expiry, the update wins.
- State PUBLISH:
  - Copy staging to q_Result_ob and pulse q_FrameValid_o for one cycle; both are visible in the cycle after PUBLISH.
  - Go to WAIT_TICK.
- Latency:
  - EnableTransfer_o is high the cycle after the tick.
  - The next slot's EnableTransfer_o is high the cycle after SpiDataUpdated_i.
  - q_FrameValid_o is high 2 cycles after the last SpiDataUpdated_i.
- Overrun:
  - A tick in any state other than WAIT_TICK or IDLE sets q_Overrun_o.
  - That tick is dropped; the current frame continues.
- Run_i deasserted mid-frame:
  - An in-flight transfer (ISSUE/WAIT_DONE) completes or times out normally.
  - The frame is then not continued or published; go to IDLE.
- q_Busy_o: 1 in ISSUE, WAIT_DONE and PUBLISH.
- Command table:
  - Written when CmdWrite_i=1 and CmdAddr_ib4<NumberOfSlots; other writes are ignored.
  - A write in the same cycle as the ISSUE load of the same slot: the old value is used, and the new value applies from the next frame.
- ClearErrors_i: clears q_TimeoutError_o, q_Overrun_o and q_TimeoutCount_ob8. If it coincides with a new error event, the set wins.
- Stray SpiDataUpdated_i outside WAIT_DONE: ignored.
- Reset mid-operation: immediate return to reset values. Any SPI transfer still in flight completes, and its completion pulse is ignored.

Decomposition:
- Package spi_sched_pkg:
  - State enum: IDLE, WAIT_TICK, ISSUE, WAIT_DONE, PUBLISH.
  - Constants: data word width 16, slot address width 4, timeout count width 8.
- One sub-module, spi_cmd_table: NumberOfSlots x 16 register file with synchronous write and combinational read.
- Period timer, FSM and staging stay in the top module.

Test Plan:
1. Common bench setup: N=2, Slots=4, Period=200, Timeout=64, SPI stub pulses SpiDataUpdated_i 18 cycles after each enable with data {cmd, cmd^16'hFFFF}. Table 0x1000..0x3000 (slots 0..3), Run_i=1 -> 4 enables per frame with Command_ob16 0x1000,0x1000+?, q_FrameValid_o every 200 cycles, q_Result_ob slot2/ch1 = 0xDFFF.
2. Stub suppresses completion on slot 1 -> q_TimeoutError_o=1, q_TimeoutCount_ob8=1, no q_FrameValid_o that period, next frame is valid; ClearErrors_i then clears all flags.
3. Period=50 with the 4x19-cycle frame -> q_Overrun_o sets, frames still complete and publish every other tick.
4. Run_i drops during slot 2 WAIT_DONE -> the transfer completes, no EnableTransfer_o for slot 3, no publish, state IDLE, q_Busy_o=0.
5. Write slot 0 with 0xABCD in the cycle its ISSUE loads -> Command_ob16 shows the old value; the next frame shows 0xABCD. A write to CmdAddr 7 is ignored.
6. Timeout expiry coincident with SpiDataUpdated_i -> data captured, no error flagged; 300 forced timeouts -> q_TimeoutCount_ob8 saturates at 255.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI sample scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package spi_sched_pkg;

  localparam int DataWidth         = 16;
  localparam int SlotAddrWidth     = 4;
  localparam int TimeoutCountWidth = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_DONE,
    PUBLISH
  } state_t;

  // Saturating increment used by the timeout tally.
  function automatic logic [TimeoutCountWidth-1:0] satIncrement(
    input logic [TimeoutCountWidth-1:0] value
  );
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/spi_cmd_table.sv
// Command word register file, one entry per frame slot.
// Latency: write takes effect at the clock edge; read is combinational.
// Backpressure: none; writes to addresses beyond the last slot are dropped.
module spi_cmd_table
  import spi_sched_pkg::*;
#(
  parameter int NumberOfSlots = 4
) (
  input  logic                     Clk_ik,
  input  logic                     Reset_i,
  input  logic                     Write_i,
  input  logic [SlotAddrWidth-1:0] WriteAddr_ib4,
  input  logic [DataWidth-1:0]     WriteData_ib16,
  input  logic [SlotAddrWidth-1:0] ReadAddr_ib4,
  output logic [DataWidth-1:0]     ReadData_ob16
);

  logic [DataWidth-1:0] entries [NumberOfSlots];

  // Synchronous write; matching only existing slots drops out-of-range addresses.
  always_ff @(posedge Clk_ik) begin
    if (Reset_i) begin
      for (int i = 0; i < NumberOfSlots; i++) entries[i] <= '0;
    end else if (Write_i) begin
      for (int i = 0; i < NumberOfSlots; i++) begin
        if (WriteAddr_ib4 == SlotAddrWidth'(i)) entries[i] <= WriteData_ib16;
      end
    end
  end

  // Combinational read; a same-cycle write is not yet visible here.
  always_comb begin
    ReadData_ob16 = '0;
    for (int i = 0; i < NumberOfSlots; i++) begin
      if (ReadAddr_ib4 == SlotAddrWidth'(i)) ReadData_ob16 = entries[i];
    end
  end

endmodule

// File: rtl/spi_sample_scheduler.sv
// Periodic frame sequencer for the multi-MISO SPI core, with timeout and overrun tracking.
// Latency: enable 1 cycle after tick or after completion; frame valid 2 cycles after last completion.
// Backpressure: none; ticks arriving mid-frame are dropped and flagged as overrun.
module spi_sample_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NumberOfMisoChannels = 1,
  parameter int NumberOfSlots        = 4,
  parameter int PeriodCycles         = 2000,
  parameter int TimeoutCycles        = 64
) (
  input  logic                                                Clk_ik,
  input  logic                                                Reset_i,
  input  logic                                                Run_i,
  input  logic                                                ClearErrors_i,
  input  logic                                                CmdWrite_i,
  input  logic [3:0]                                          CmdAddr_ib4,
  input  logic [15:0]                                         CmdData_ib16,
  output logic                                                EnableTransfer_o,
  output logic [15:0]                                         Command_ob16,
  input  logic [16*NumberOfMisoChannels-1:0]                  SpiData_ib,
  input  logic                                                SpiDataUpdated_i,
  output logic [16*NumberOfMisoChannels*NumberOfSlots-1:0]    q_Result_ob,
  output logic                                                q_FrameValid_o,
  output logic                                                q_Busy_o,
  output logic                                                q_TimeoutError_o,
  output logic                                                q_Overrun_o,
  output logic [7:0]                                          q_TimeoutCount_ob8
);

  localparam int SlotBits     = DataWidth * NumberOfMisoChannels;
  localparam int PeriodWidth  = (PeriodCycles > 1) ? $clog2(PeriodCycles) : 1;
  localparam int TimeoutWidth = $clog2(TimeoutCycles);
  localparam logic [PeriodWidth-1:0]   PeriodLast  = PeriodWidth'(PeriodCycles - 1);
  localparam logic [TimeoutWidth-1:0]  TimeoutLast = TimeoutWidth'(TimeoutCycles - 1);
  localparam logic [SlotAddrWidth-1:0] LastSlot    = SlotAddrWidth'(NumberOfSlots - 1);

  state_t                          state;
  state_t                          nextState;
  logic [PeriodWidth-1:0]          periodCount;
  logic [TimeoutWidth-1:0]         timeoutCount;
  logic [SlotAddrWidth-1:0]        slot;
  logic [SlotAddrWidth-1:0]        loadSlot;
  logic [DataWidth-1:0]            tableReadData;
  logic [SlotBits*NumberOfSlots-1:0] staging;
  logic                            tick;
  logic                            issueLoad;
  logic                            spiDone;
  logic                            timeoutHit;
  logic                            overrunHit;

  assign tick       = Run_i && (periodCount == PeriodLast);
  assign issueLoad  = (nextState == ISSUE);
  assign loadSlot   = (state == WAIT_DONE) ? slot + 1'b1 : '0;
  assign spiDone    = (state == WAIT_DONE) && SpiDataUpdated_i;
  // A completion in the expiry cycle takes priority over the timeout.
  assign timeoutHit = (state == WAIT_DONE) && !SpiDataUpdated_i && (timeoutCount == TimeoutLast);
  assign overrunHit = tick && (state != WAIT_TICK) && (state != IDLE);

  spi_cmd_table #(
    .NumberOfSlots (NumberOfSlots)
  ) cmdTable (
    .Clk_ik         (Clk_ik),
    .Reset_i        (Reset_i),
    .Write_i        (CmdWrite_i),
    .WriteAddr_ib4  (CmdAddr_ib4),
    .WriteData_ib16 (CmdData_ib16),
    .ReadAddr_ib4   (loadSlot),
    .ReadData_ob16  (tableReadData)
  );

  // Free-running period counter while running, parked at zero otherwise.
  always_ff @(posedge Clk_ik) begin
    if (Reset_i || !Run_i || periodCount == PeriodLast) periodCount <= '0;
    else                                                periodCount <= periodCount + 1'b1;
  end

  // State register.
  always_ff @(posedge Clk_ik) begin
    if (Reset_i) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic; losing Run_i ends the frame once the current transfer resolves.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (Run_i) nextState = WAIT_TICK;
      WAIT_TICK: begin
        if (!Run_i)    nextState = IDLE;
        else if (tick) nextState = ISSUE;
      end
      ISSUE:     nextState = WAIT_DONE;
      WAIT_DONE: begin
        if (SpiDataUpdated_i) begin
          if (!Run_i)                nextState = IDLE;
          else if (slot == LastSlot) nextState = PUBLISH;
          else                       nextState = ISSUE;
        end else if (timeoutHit) begin
          nextState = Run_i ? WAIT_TICK : IDLE;
        end
      end
      PUBLISH:   nextState = WAIT_TICK;
      default:   nextState = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    EnableTransfer_o = 1'b0;
    q_Busy_o         = 1'b0;
    case (state)
      ISSUE:            begin EnableTransfer_o = 1'b1; q_Busy_o = 1'b1; end
      WAIT_DONE, PUBLISH: q_Busy_o = 1'b1;
      default:          ;
    endcase
  end

  // Slot index and command word are latched on entry to ISSUE; timeout counter runs in WAIT_DONE.
  always_ff @(posedge Clk_ik) begin
    if (Reset_i) begin
      slot         <= '0;
      Command_ob16 <= '0;
      timeoutCount <= '0;
    end else begin
      if (issueLoad) begin
        slot         <= loadSlot;
        Command_ob16 <= tableReadData;
      end
      if (state == ISSUE)          timeoutCount <= '0;
      else if (state == WAIT_DONE) timeoutCount <= timeoutCount + 1'b1;
    end
  end

  // Capture each slot's multi-channel word as its completion arrives.
  always_ff @(posedge Clk_ik) begin
    if (Reset_i) begin
      staging <= '0;
    end else if (spiDone) begin
      for (int s = 0; s < NumberOfSlots; s++) begin
        if (slot == SlotAddrWidth'(s)) staging[s*SlotBits +: SlotBits] <= SpiData_ib;
      end
    end
  end

  // Publish the whole frame at once, visible the cycle after PUBLISH.
  always_ff @(posedge Clk_ik) begin
    if (Reset_i) begin
      q_Result_ob    <= '0;
      q_FrameValid_o <= 1'b0;
    end else begin
      q_FrameValid_o <= (state == PUBLISH);
      if (state == PUBLISH) q_Result_ob <= staging;
    end
  end

  // Sticky error flags and timeout tally; a new event beats a coincident clear.
  always_ff @(posedge Clk_ik) begin
    if (Reset_i) begin
      q_TimeoutError_o   <= 1'b0;
      q_Overrun_o        <= 1'b0;
      q_TimeoutCount_ob8 <= '0;
    end else begin
      if (timeoutHit)         q_TimeoutError_o <= 1'b1;
      else if (ClearErrors_i) q_TimeoutError_o <= 1'b0;

      if (overrunHit)         q_Overrun_o <= 1'b1;
      else if (ClearErrors_i) q_Overrun_o <= 1'b0;

      if (timeoutHit)         q_TimeoutCount_ob8 <= ClearErrors_i ? 8'd1 : satIncrement(q_TimeoutCount_ob8);
      else if (ClearErrors_i) q_TimeoutCount_ob8 <= '0;
    end
  end

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// Directed bench: two scheduler instances (200- and 50-cycle periods) with SPI core stubs.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_sample_scheduler;

  logic         clk = 1'b0;
  logic         reset, runA, runB, clearErrors, cmdWrite;
  logic [3:0]   cmdAddr;
  logic [15:0]  cmdData;

  logic         enA, fvA, busyA, toA, ovA, updA;
  logic [15:0]  cmdA, latchA;
  logic [31:0]  spiDataA;
  logic [127:0] resultA;
  logic [7:0]   tocA;

  logic         enB, fvB, busyB, toB, ovB, updB;
  logic [15:0]  cmdB, latchB;
  logic [31:0]  spiDataB;
  logic [127:0] resultB;
  logic [7:0]   tocB;

  // Stub A: 18-cycle completion, or per-command override (1 = never, 2 = 64 cycles).
  int           cntA = 0, cntB = 0;
  int           altModeA = 0;
  logic [15:0]  altCmdA = 16'h0;
  bit           muteB = 1'b0;

  int           nAsserts = 0, nFail = 0;
  int           enCountA = 0, fvCountA = 0;
  logic [15:0]  tbl [4];

  always #5 clk = ~clk;

  spi_sample_scheduler #(
    .NumberOfMisoChannels(2), .NumberOfSlots(4), .PeriodCycles(200), .TimeoutCycles(64)
  ) dutA (
    .Clk_ik(clk), .Reset_i(reset), .Run_i(runA), .ClearErrors_i(clearErrors),
    .CmdWrite_i(cmdWrite), .CmdAddr_ib4(cmdAddr), .CmdData_ib16(cmdData),
    .EnableTransfer_o(enA), .Command_ob16(cmdA), .SpiData_ib(spiDataA),
    .SpiDataUpdated_i(updA), .q_Result_ob(resultA), .q_FrameValid_o(fvA),
    .q_Busy_o(busyA), .q_TimeoutError_o(toA), .q_Overrun_o(ovA),
    .q_TimeoutCount_ob8(tocA)
  );

  spi_sample_scheduler #(
    .NumberOfMisoChannels(2), .NumberOfSlots(4), .PeriodCycles(50), .TimeoutCycles(64)
  ) dutB (
    .Clk_ik(clk), .Reset_i(reset), .Run_i(runB), .ClearErrors_i(clearErrors),
    .CmdWrite_i(cmdWrite), .CmdAddr_ib4(cmdAddr), .CmdData_ib16(cmdData),
    .EnableTransfer_o(enB), .Command_ob16(cmdB), .SpiData_ib(spiDataB),
    .SpiDataUpdated_i(updB), .q_Result_ob(resultB), .q_FrameValid_o(fvB),
    .q_Busy_o(busyB), .q_TimeoutError_o(toB), .q_Overrun_o(ovB),
    .q_TimeoutCount_ob8(tocB)
  );

  // SPI stubs: channel 0 echoes the command, channel 1 carries its complement.
  always @(negedge clk) begin
    updA = 1'b0;
    if (cntA > 0) begin
      cntA--;
      if (cntA == 0) begin updA = 1'b1; spiDataA = {~latchA, latchA}; end
    end
    if (enA) begin
      latchA = cmdA;
      if (altModeA == 1 && cmdA == altCmdA)      cntA = 0;
      else if (altModeA == 2 && cmdA == altCmdA) cntA = 64;
      else                                       cntA = 18;
    end
  end

  always @(negedge clk) begin
    updB = 1'b0;
    if (cntB > 0) begin
      cntB--;
      if (cntB == 0) begin updB = 1'b1; spiDataB = {~latchB, latchB}; end
    end
    if (enB) begin
      latchB = cmdB;
      cntB   = muteB ? 0 : 18;
    end
  end

  always @(posedge clk) begin
    if (enA) enCountA++;
    if (fvA) fvCountA++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit probe(input int which);
    case (which)
      0: return enA;
      1: return fvA;
      2: return toA;
      3: return enB;
      4: return fvB;
      5: return ovB;
      6: return toB;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait for an output event; returns the number of cycles waited.
  task automatic waitFor(input int which, input int budget, input string tag, output int cycles);
    bit hit;
    hit    = 1'b0;
    cycles = 0;
    while (!hit && cycles < budget) begin
      tick();
      cycles++;
      hit = probe(which);
    end
    nAsserts++;
    assert (hit) else begin
      nFail++;
      $error("FAIL %s: observed no event within %0d cycles, expected an event", tag, budget);
    end
  endtask

  task automatic writeCmd(input logic [3:0] a, input logic [15:0] d);
    cmdWrite = 1'b1; cmdAddr = a; cmdData = d;
    tick();
    cmdWrite = 1'b0;
  endtask

  function automatic logic [127:0] expFrame();
    logic [127:0] r;
    r = '0;
    for (int s = 0; s < 4; s++) begin
      r[s*32 +: 16]      = tbl[s];
      r[s*32 + 16 +: 16] = ~tbl[s];
    end
    return r;
  endfunction

  initial begin
    int c;
    int enSnap, fvSnap;
    logic [15:0] slice;

    reset = 1'b1; runA = 1'b0; runB = 1'b0; clearErrors = 1'b0;
    cmdWrite = 1'b0; cmdAddr = '0; cmdData = '0;
    repeat (3) tick();
    chk("reset_enable", enA, 0);
    chk("reset_command", cmdA, 0);
    chk("reset_result", resultA, 0);
    chk("reset_flags", {fvA, busyA, toA, ovA}, 0);
    chk("reset_tally", tocA, 0);
    reset = 1'b0;
    tick();

    tbl[0] = 16'h1000; tbl[1] = 16'h1800; tbl[2] = 16'h2000; tbl[3] = 16'h3000;
    for (int s = 0; s < 4; s++) writeCmd(4'(s), tbl[s]);
    writeCmd(4'd7, 16'hBEEF);

    // Normal frames
    runA = 1'b1;
    waitFor(0, 250, "first_enable", c);
    chk("first_enable_latency", c, 200);
    chk("slot0_command", cmdA, 16'h1000);
    chk("busy_in_issue", busyA, 1);
    for (int s = 1; s < 4; s++) begin
      waitFor(0, 40, "slot_enable", c);
      chk("slot_spacing", c, 19);
      chk("slot_command", cmdA, tbl[s]);
    end
    waitFor(1, 40, "frame_valid", c);
    chk("publish_latency", c, 20);
    chk("frame_data", resultA, expFrame());
    slice = resultA[80 +: 16];
    chk("slot2_ch1", slice, 16'hDFFF);
    tick();
    chk("frame_valid_one_cycle", fvA, 0);
    waitFor(1, 250, "second_frame", c);
    chk("frame_period", c, 199);

    // Table write coinciding with the slot-0 load
    repeat (122) tick();
    cmdWrite = 1'b1; cmdAddr = 4'd0; cmdData = 16'hABCD;
    tick();
    cmdWrite = 1'b0;
    chk("issue_during_write", enA, 1);
    chk("old_command_used", cmdA, 16'h1000);
    waitFor(1, 100, "frame_old_cmd", c);
    chk("frame_with_old_cmd", resultA, expFrame());
    tbl[0] = 16'hABCD;
    waitFor(0, 200, "enable_new_cmd", c);
    chk("new_command_applied", cmdA, 16'hABCD);
    waitFor(1, 100, "frame_new_cmd", c);
    chk("frame_with_new_cmd", resultA, expFrame());
    writeCmd(4'd0, 16'h1000);
    tbl[0] = 16'h1000;

    // Missing completion on slot 1
    fvSnap = fvCountA;
    altCmdA = 16'h1800; altModeA = 1;
    waitFor(0, 200, "timeout_frame_slot0", c);
    waitFor(0, 40, "timeout_frame_slot1", c);
    chk("slot1_command", cmdA, 16'h1800);
    waitFor(2, 100, "timeout_flag", c);
    chk("timeout_latency", c, 65);
    chk("timeout_tally_one", tocA, 1);
    chk("idle_after_timeout", busyA, 0);
    chk("no_publish_on_timeout", fvCountA, fvSnap);
    altModeA = 0;
    waitFor(1, 250, "frame_after_timeout", c);
    chk("recovered_frame", resultA, expFrame());
    chk("timeout_sticky", toA, 1);
    clearErrors = 1'b1;
    tick();
    clearErrors = 1'b0;
    chk("clear_flags", {toA, ovA}, 0);
    chk("clear_tally", tocA, 0);

    // Completion in the expiry cycle
    altModeA = 2;
    waitFor(1, 300, "coincident_frame", c);
    chk("coincident_publish_time", c, 245);
    chk("coincident_frame_data", resultA, expFrame());
    chk("coincident_no_error", {toA, tocA}, 0);
    altModeA = 0;

    // Run dropped during slot 2
    waitFor(0, 250, "stop_slot0", c);
    waitFor(0, 40, "stop_slot1", c);
    waitFor(0, 40, "stop_slot2", c);
    chk("stop_slot2_command", cmdA, 16'h2000);
    repeat (5) tick();
    enSnap = enCountA; fvSnap = fvCountA;
    runA = 1'b0;
    repeat (10) tick();
    chk("busy_while_in_flight", busyA, 1);
    repeat (40) tick();
    chk("no_slot3_enable", enCountA, enSnap);
    chk("no_publish_after_stop", fvCountA, fvSnap);
    chk("idle_after_stop", busyA, 0);
    runA = 1'b1;
    waitFor(0, 250, "restart_enable", c);
    chk("restart_latency", c, 200);
    runA = 1'b0;
    repeat (30) tick();
    chk("idle_after_restart_stop", busyA, 0);

    // Short period: overrun
    runB = 1'b1;
    waitFor(3, 80, "b_first_enable", c);
    chk("b_first_enable_latency", c, 50);
    waitFor(5, 80, "b_overrun", c);
    chk("b_overrun_latency", c, 50);
    waitFor(4, 60, "b_frame", c);
    chk("b_publish_latency", c, 27);
    chk("b_frame_data", resultB, expFrame());
    waitFor(4, 150, "b_next_frame", c);
    chk("b_every_other_tick", c, 100);
    clearErrors = 1'b1;
    tick();
    clearErrors = 1'b0;
    chk("b_clear_flags", {toB, ovB}, 0);

    // Tally saturation
    muteB = 1'b1;
    waitFor(6, 200, "b_first_timeout", c);
    chk("b_timeout_latency", c, 87);
    chk("b_tally_one", tocB, 1);
    repeat (30600) tick();
    chk("b_tally_saturated", tocB, 255);
    chk("b_timeout_flag", toB, 1);
    runB = 1'b0; muteB = 1'b0;

    // Reset mid-transfer; the late completion must be ignored
    runA = 1'b1;
    waitFor(0, 250, "reset_test_enable", c);
    repeat (3) tick();
    reset = 1'b1; runA = 1'b0;
    tick();
    chk("midreset_busy", busyA, 0);
    chk("midreset_command", cmdA, 0);
    chk("midreset_result", resultA, 0);
    fvSnap = fvCountA; enSnap = enCountA;
    tick();
    reset = 1'b0;
    repeat (30) tick();
    chk("stray_completion_busy", busyA, 0);
    chk("stray_completion_no_publish", fvCountA, fvSnap);
    chk("stray_completion_no_enable", enCountA, enSnap);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
